lsu_data_memory: RTL and testbench
==================================

// Module: lsu_data_memory
// PURPOSE
//  Byte-addressable data memory with load/store unit front-end: B/H/W/D sizes, sign/zero-extending loads,
//  req/resp handshake, range checking, sequenced clear after reset. Sits on the datapath memory stage.
//  Storage is a word array of XLEN/8 byte lanes with byte-enable writes.
// PARAMETERS
//  XLEN        64    data/address width; 32 or 64
//  DEPTH_BYTES 1024  capacity in bytes; power of two, multiple of XLEN/8
// PORTS
//  clk           in   1     clock
//  rstn          in   1     reset, synchronous, active-low
//  req_valid     in   1     request present
//  req_ready     out  1     block can accept; transfer when req_valid && req_ready
//  req_write     in   1     1 = store, 0 = load
//  req_size      in   2     0=B 1=H 2=W 3=D
//  req_unsigned  in   1     load zero-extends when 1, sign-extends when 0
//  req_addr      in   XLEN  byte address
//  req_wdata     in   XLEN  store data, low bytes used
//  resp_valid    out  1     one-cycle response pulse; no back-pressure
//  resp_rdata    out  XLEN  load data, extended; 0 for stores and errors
//  resp_err      out  1     access fault, valid with resp_valid
//  init_done     out  1     clear sequence complete
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> INIT; in-flight split aborted, pending second beat discarded.
//  INIT: clears one word/cycle via counter, DEPTH_BYTES/(XLEN/8) cycles; then init_done=1, -> IDLE.
//  IDLE: req_ready=1. Single-beat access performed at the accept edge; resp_valid next cycle.
//    Back-to-back single-beat requests sustain 1/cycle; load after store to same address sees new data.
//  SPLIT: access crossing a word boundary; beat 1 at accept edge, req_ready=0 one cycle, beat 2 next
//    edge, resp_valid the cycle after (2-cycle latency). Then IDLE.
//  Errors (resp_err=1, rdata=0, no bytes written, single-beat timing):
//    any byte of access >= DEPTH_BYTES (checked on both beats before beat 1 commits);
//    req_size=3 with XLEN=32; misalignment per CONFIGURATION.
//  Address arithmetic: byte offset addr[$clog2(XLEN/8)-1:0]; word index addr/(XLEN/8); no wrap at top.
//  Load extension from bit 8*2^size-1 unless req_unsigned; D loads unextended.
//  Stores write only the 2^size addressed bytes; other lanes untouched.
// CONFIGURATION
//  DM_MISALIGNED_SPLIT_EN defined: misaligned inside a word -> single beat; crossing word -> SPLIT.
//  Undefined: any addr not a multiple of 2^size -> resp_err, no write; SPLIT state not built.
// STRUCTURE
//  Package dm_pkg: size enum (DM_B/H/W/D), FSM state enum (INIT/IDLE/SPLIT), function size_bytes(),
//    function extend(data,size,unsigned).
//  Sub-module dm_word_ram: word array, byte-enable synchronous write, async read, clear port.
// TESTING
//  Reset 1 cycle -> init_done rises after 128 cycles (XLEN=64); req_ready=0 until then; all reads 0.
//  SD 0x1122334455667788 @0x10, LB @0x10 signed -> 0xFFFF...FF88; LBU -> 0x88; LW @0x14 -> 0x11223344.
//  SB 0xAB @0x13 then LD @0x10 -> only byte 3 changed; back-to-back pair: 1 resp per cycle.
//  LD @0x3FC (DEPTH 1024) -> resp_err=1, rdata=0; SD there -> no bytes written (verify 0x3F8 word).
//  LW @0x0E: with macro -> 2-cycle resp, correct data across words; without -> resp_err, no write.
//  rstn low during SPLIT -> no resp_valid, FSM INIT, memory cleared, init_done=0 until re-done.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared types and helpers for the LSU data memory.
//   dm_size_e  - access size encoding (B/H/W/D = 1/2/4/8 bytes)
//   dm_state_e - controller states
//   size_bytes - byte count of an access size
//   extend     - sign/zero extension of a right-justified load value
package dm_pkg;

  localparam int unsigned DM_MAX_XLEN = 64;

  typedef enum logic [1:0] {
    DM_B = 2'd0,
    DM_H = 2'd1,
    DM_W = 2'd2,
    DM_D = 2'd3
  } dm_size_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SPLIT = 2'd2
  } dm_state_e;

  function automatic logic [3:0] size_bytes(input dm_size_e size);
    return 4'd1 << size;
  endfunction

  // Extension starts at the top bit of the accessed field; D is returned as-is.
  function automatic logic [DM_MAX_XLEN-1:0] extend(input logic [DM_MAX_XLEN-1:0] data,
                                                    input dm_size_e size,
                                                    input logic is_unsigned);
    logic [DM_MAX_XLEN-1:0] res;
    case (size)
      DM_B:    res = is_unsigned ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      DM_H:    res = is_unsigned ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      DM_W:    res = is_unsigned ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// dm_word_ram: word-organised storage with byte-enable synchronous write,
// asynchronous read and a clear port used by the post-reset clear sequence.
// Ports:
//   clk        clock
//   clr_i      zero the word at clr_idx_i (wins over a write)
//   clr_idx_i  word to clear
//   we_i       write enable
//   widx_i     word to write
//   wbe_i      byte lane enables
//   wdata_i    write data, lane-aligned
//   ridx_i     word to read
//   rdata_o    read data (combinational)
module dm_word_ram #(
  parameter  int unsigned NB     = 8,
  parameter  int unsigned NWORDS = 128,
  localparam int unsigned IDXW   = $clog2(NWORDS)
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic [IDXW-1:0] clr_idx_i,
  input  logic            we_i,
  input  logic [IDXW-1:0] widx_i,
  input  logic [NB-1:0]   wbe_i,
  input  logic [8*NB-1:0] wdata_i,
  input  logic [IDXW-1:0] ridx_i,
  output logic [8*NB-1:0] rdata_o
);

  logic [8*NB-1:0] mem_q [NWORDS];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/lsu_data_memory.sv
// lsu_data_memory: byte-addressable data memory with a load/store front-end.
// B/H/W/D accesses, sign/zero-extended loads, req/resp handshake, range
// checking and a one-word-per-cycle clear sequence after reset.
// Build option: DM_MISALIGNED_SPLIT_EN - when defined, misaligned accesses are
// supported (word-crossing ones take two beats); otherwise they fault.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   req_valid / req_ready     request handshake
//   req_write, req_size       store flag, size (0=B 1=H 2=W 3=D)
//   req_unsigned              zero-extend loads
//   req_addr, req_wdata       byte address, store data (low bytes)
//   resp_valid                one-cycle response pulse
//   resp_rdata, resp_err      extended load data (0 for stores/errors), fault
//   init_done                 clear sequence finished
//
// state    | meaning
// ST_INIT  | clearing memory, one word per cycle, req_ready low
// ST_IDLE  | accepting requests, single-beat access at the accept edge
// ST_SPLIT | second beat of a word-crossing access (split build only)
module lsu_data_memory
  import dm_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            init_done
);

  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned OFFW   = $clog2(NB);
  localparam int unsigned NWORDS = DEPTH_BYTES / NB;
  localparam int unsigned IDXW   = $clog2(NWORDS);

  dm_state_e       state_q;
  logic [IDXW-1:0] clr_cnt_q;
  logic            ready_q, init_done_q, resp_valid_q, resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;

  dm_size_e          size_in;
  logic [3:0]        nbytes;
  logic [OFFW-1:0]   off_in;
  logic [IDXW-1:0]   idx_in;
  logic [XLEN:0]     last_byte;
  logic              range_err, size_err, req_err, accept;
  logic [2*NB-1:0]   lane_mask;
  logic [2*XLEN-1:0] wdata_ext;
  logic [NB-1:0]     be_lo;
  logic [XLEN-1:0]   wd_lo;

  logic            ram_clr, ram_we;
  logic [IDXW-1:0] ram_widx, ram_ridx;
  logic [NB-1:0]   ram_wbe;
  logic [XLEN-1:0] ram_wdata, ram_rdata;

  logic [OFFW-1:0]        cur_off;
  dm_size_e               cur_size;
  logic                   cur_uns;
  logic [XLEN-1:0]        lo_word, hi_word, raw, load_data;
  logic [DM_MAX_XLEN-1:0] ext_in, ext_out;

`ifdef DM_MISALIGNED_SPLIT_EN
  logic            cross;
  logic [NB-1:0]   be_hi;
  logic [XLEN-1:0] wd_hi;
  logic [IDXW-1:0] sp_idx_q;
  logic [OFFW-1:0] sp_off_q;
  dm_size_e        sp_size_q;
  logic            sp_uns_q, sp_write_q;
  logic [XLEN-1:0] sp_lo_q, sp_wdata_q;
  logic [NB-1:0]   sp_be_q;
`endif

  assign size_in   = dm_size_e'(req_size);
  assign nbytes    = size_bytes(size_in);
  assign off_in    = req_addr[OFFW-1:0];
  assign idx_in    = req_addr[OFFW+IDXW-1:OFFW];
  // One bit wider than the address so the top-of-range check cannot wrap.
  assign last_byte = {1'b0, req_addr} + (XLEN+1)'(nbytes) - (XLEN+1)'(1);
  assign range_err = last_byte >= (XLEN+1)'(DEPTH_BYTES);
  assign size_err  = (XLEN == 32) && (size_in == DM_D);
  assign accept    = req_valid && ready_q;

  // Access laid out over two consecutive words; low half is the addressed word.
  assign lane_mask = (2*NB)'((17'd1 << nbytes) - 17'd1);
  assign wdata_ext = {{XLEN{1'b0}}, req_wdata};
  assign be_lo     = NB'(lane_mask << off_in);
  assign wd_lo     = XLEN'(wdata_ext << {off_in, 3'b000});

`ifdef DM_MISALIGNED_SPLIT_EN
  assign cross   = (int'(off_in) + int'(nbytes)) > int'(NB);
  assign be_hi   = NB'((lane_mask << off_in) >> NB);
  assign wd_hi   = XLEN'((wdata_ext << {off_in, 3'b000}) >> XLEN);
  assign req_err = range_err || size_err;
`else
  assign req_err = range_err || size_err ||
                   ((req_addr[OFFW-1:0] & OFFW'(nbytes - 4'd1)) != '0);
`endif

  // RAM port steering; writes are masked while reset is asserted so an
  // aborted second beat never lands.
  always_comb begin
    ram_clr   = (state_q == ST_INIT);
    ram_we    = rstn && accept && req_write && !req_err;
    ram_widx  = idx_in;
    ram_wbe   = be_lo;
    ram_wdata = wd_lo;
    ram_ridx  = idx_in;
`ifdef DM_MISALIGNED_SPLIT_EN
    if (state_q == ST_SPLIT) begin
      ram_we    = rstn && sp_write_q;
      ram_widx  = sp_idx_q;
      ram_wbe   = sp_be_q;
      ram_wdata = sp_wdata_q;
      ram_ridx  = sp_idx_q;
    end
`endif
  end

  always_comb begin
    cur_off  = off_in;
    cur_size = size_in;
    cur_uns  = req_unsigned;
    lo_word  = ram_rdata;
    hi_word  = '0;
`ifdef DM_MISALIGNED_SPLIT_EN
    if (state_q == ST_SPLIT) begin
      cur_off  = sp_off_q;
      cur_size = sp_size_q;
      cur_uns  = sp_uns_q;
      lo_word  = sp_lo_q;
      hi_word  = ram_rdata;
    end
`endif
    raw       = XLEN'({hi_word, lo_word} >> {cur_off, 3'b000});
    ext_in    = DM_MAX_XLEN'(raw);
    ext_out   = extend(ext_in, cur_size, cur_uns);
    load_data = ext_out[XLEN-1:0];
  end

  dm_word_ram #(.NB(NB), .NWORDS(NWORDS)) u_ram (
    .clk      (clk),
    .clr_i    (ram_clr),
    .clr_idx_i(clr_cnt_q),
    .we_i     (ram_we),
    .widx_i   (ram_widx),
    .wbe_i    (ram_wbe),
    .wdata_i  (ram_wdata),
    .ridx_i   (ram_ridx),
    .rdata_o  (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_INIT;
      clr_cnt_q    <= IDXW'(NWORDS - 1);
      ready_q      <= 1'b0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_INIT: begin
          if (clr_cnt_q == '0) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q - 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
`ifdef DM_MISALIGNED_SPLIT_EN
            end else if (cross) begin
              state_q    <= ST_SPLIT;
              ready_q    <= 1'b0;
              sp_idx_q   <= idx_in + 1'b1;
              sp_off_q   <= off_in;
              sp_size_q  <= size_in;
              sp_uns_q   <= req_unsigned;
              sp_write_q <= req_write;
              sp_lo_q    <= ram_rdata;
              sp_be_q    <= be_hi;
              sp_wdata_q <= wd_hi;
`endif
            end else begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= req_write ? '0 : load_data;
            end
          end
        end
`ifdef DM_MISALIGNED_SPLIT_EN
        ST_SPLIT: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= sp_write_q ? '0 : load_data;
        end
`endif
        default: begin
          state_q     <= ST_INIT;
          clr_cnt_q   <= IDXW'(NWORDS - 1);
          ready_q     <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
module tb_lsu_data_memory;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [1:0]      req_size = 2'd0;
  logic            req_unsigned = 1'b0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            init_done;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference memory: one entry per byte address.
  logic [7:0] mdl_mem [DEPTH];

  always #5 clk = ~clk;

  lsu_data_memory #(.XLEN(XLEN), .DEPTH_BYTES(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .init_done   (init_done)
  );

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
  endtask

  // Applies one access to the byte model and predicts the response.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                              input logic [63:0] a, input logic [63:0] wd,
                              output logic e, output logic [63:0] rd, output logic sp);
    int unsigned n;
    logic [63:0] v;
    n  = 1 << sz;
    e  = 1'b0;
    sp = 1'b0;
    rd = 64'd0;
    if (a + n - 1 >= DEPTH) e = 1'b1;
`ifdef DM_MISALIGNED_SPLIT_EN
    if (!e && ((a % 8) + n) > 8) sp = 1'b1;
`else
    if ((a % n) != 0) e = 1'b1;
`endif
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl_mem[int'(a) + i];
        if (!u && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        rd = v;
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge showing the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd, output logic [63:0] got);
    logic e, sp;
    logic [63:0] rd;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_req addr=%h got=%b exp=1", a, req_ready);
    end
    model_access(w, sz, u, a, wd, e, rd, sp);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    if (sp) begin
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL split_beat1 addr=%h got valid=%b ready=%b exp 0/0", a, resp_valid, req_ready);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== e || resp_rdata !== rd) begin
      n_fail++;
      $display("FAIL resp w=%b sz=%0d u=%b addr=%h got v=%b e=%b d=%h exp v=1 e=%b d=%h",
               w, sz, u, a, resp_valid, resp_err, resp_rdata, e, rd);
    end
    got = resp_rdata;
  endtask

  task automatic test_reset();
    int cyc, bad_ready;
    logic [63:0] got;
    rstn = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, init_done} !== 4'b0000 || resp_rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b v=%b e=%b done=%b d=%h exp all 0",
               req_ready, resp_valid, resp_err, init_done, resp_rdata);
    end
    rstn = 1'b1;
    cyc = 0;
    bad_ready = 0;
    while (init_done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (init_done !== 1'b1 && req_ready !== 1'b0) bad_ready++;
    end
    n_cmp++;
    if (cyc != 128) begin
      n_fail++;
      $display("FAIL init_cycles got=%0d exp=128", cyc);
    end
    n_cmp++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL ready_during_init got=%0d cycles high exp=0", bad_ready);
    end
    model_clear();
    for (int i = 0; i < 6; i++)
      do_req(1'b0, 2'd3, 1'b0, 64'(8 * $urandom_range(0, DEPTH/8 - 1)), 64'd0, got);
  endtask

  task automatic test_spec_vectors();
    logic [63:0] got;
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, got);
    do_req(1'b0, 2'd0, 1'b0, 64'h10, 64'd0, got);
    n_cmp++;
    if (got !== 64'hFFFF_FFFF_FFFF_FF88) begin
      n_fail++; $display("FAIL lb_signed got=%h exp=ffffffffffffff88", got);
    end
    do_req(1'b0, 2'd0, 1'b1, 64'h10, 64'd0, got);
    n_cmp++;
    if (got !== 64'h88) begin
      n_fail++; $display("FAIL lbu got=%h exp=88", got);
    end
    do_req(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, got);
    n_cmp++;
    if (got !== 64'h11223344) begin
      n_fail++; $display("FAIL lw_0x14 got=%h exp=11223344", got);
    end
    do_req(1'b1, 2'd0, 1'b0, 64'h13, 64'h55AA_55AA_55AA_55AB, got);
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, got);
    n_cmp++;
    if (got !== 64'h11223344AB667788) begin
      n_fail++; $display("FAIL sb_then_ld got=%h exp=11223344ab667788", got);
    end
    do_req(1'b0, 2'd1, 1'b0, 64'h12, 64'd0, got);
    n_cmp++;
    if (got !== 64'hFFFF_FFFF_FFFF_AB66) begin
      n_fail++; $display("FAIL lh_signed got=%h exp=ffffffffffffab66", got);
    end
  endtask

  task automatic test_range();
    logic [63:0] got;
    do_req(1'b1, 2'd3, 1'b0, 64'h3F8, 64'hDEADBEEFCAFEF00D, got);
    do_req(1'b0, 2'd3, 1'b0, 64'h3FC, 64'd0, got);
    do_req(1'b1, 2'd3, 1'b0, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, got);
    do_req(1'b0, 2'd3, 1'b0, 64'h3F8, 64'd0, got);
    n_cmp++;
    if (got !== 64'hDEADBEEFCAFEF00D) begin
      n_fail++; $display("FAIL range_no_write got=%h exp=deadbeefcafef00d", got);
    end
    do_req(1'b0, 2'd0, 1'b1, 64'h3FF, 64'd0, got);
    do_req(1'b0, 2'd1, 1'b0, 64'h3FF, 64'd0, got);
    do_req(1'b0, 2'd0, 1'b0, 64'h400, 64'd0, got);
  endtask

  task automatic test_misaligned();
    logic [63:0] got;
    do_req(1'b1, 2'd3, 1'b0, 64'h08, 64'h8877665544332211, got);
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'hFFEEDDCCBBAA9988, got);
    do_req(1'b0, 2'd2, 1'b0, 64'h0E, 64'd0, got);
    n_cmp++;
`ifdef DM_MISALIGNED_SPLIT_EN
    if (got !== 64'hFFFF_FFFF_9988_8877) begin
      n_fail++; $display("FAIL lw_0x0e got=%h exp=ffffffff99888877", got);
    end
`else
    if (got !== 64'd0) begin
      n_fail++; $display("FAIL lw_0x0e got=%h exp=0", got);
    end
`endif
    do_req(1'b0, 2'd1, 1'b1, 64'h09, 64'd0, got);
    do_req(1'b1, 2'd2, 1'b0, 64'h0E, 64'h00000000A1B2C3D4, got);
    do_req(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, got);
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, got);
    do_req(1'b1, 2'd3, 1'b0, 64'h0B, 64'h0102030405060708, got);
    do_req(1'b0, 2'd3, 1'b1, 64'h0B, 64'd0, got);
  endtask

  // One request per cycle: store then load of the same word, each response
  // checked at the negedge following its accept edge.
  task automatic test_back_to_back();
    logic [63:0] a, wd, rd;
    logic w, u, e, sp;
    logic [1:0] sz;
    a = 64'd0;
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_ready);
      end
      if (i % 2 == 0) begin
        a  = 64'(8 * $urandom_range(0, 7));
        w  = 1'b1;
        sz = 2'd3;
        u  = 1'b0;
        wd = {$urandom, $urandom};
      end else begin
        w  = 1'b0;
        sz = 2'($urandom_range(0, 3));
        u  = 1'($urandom_range(0, 1));
        wd = 64'd0;
      end
      model_access(w, sz, u, a, wd, e, rd, sp);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_err !== e || resp_rdata !== rd) begin
        n_fail++;
        $display("FAIL b2b_resp i=%0d addr=%h got v=%b e=%b d=%h exp v=1 e=%b d=%h",
                 i, a, resp_valid, resp_err, resp_rdata, e, rd);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got=%b exp=0", resp_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, got;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = 64'($urandom_range(DEPTH - 16, DEPTH + 8));
      else a = 64'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, {$urandom, $urandom}, got);
    end
  endtask

  task automatic test_reset_during_split();
    logic [63:0] got;
    int cyc;
    do_req(1'b1, 2'd3, 1'b0, 64'h08, 64'h0123456789ABCDEF, got);
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'hFEDCBA9876543210, got);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 64'h0E; req_wdata = 64'h55AA55AA;
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_split got v=%b done=%b rdy=%b exp 0/0/0", resp_valid, init_done, req_ready);
    end
    rstn = 1'b1;
    model_clear();
    cyc = 0;
    while (init_done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 128) begin
      n_fail++; $display("FAIL reinit_cycles got=%0d exp=128", cyc);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, got);
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, got);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_range();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_during_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
